// File: rtl/plat_scroll_sched.sv
// Once-per-frame scroll scheduler for the platform position file: computes the
// scroll amount, walks every slot once, respawns fallen platforms, keeps score.
module plat_scroll_sched #(
    parameter int NUM_PLAT    = 16,
    parameter int SCREEN_H    = 480,
    parameter int FIELD_W     = 320,
    parameter int PLAT_W      = 40,
    parameter int SCROLL_LINE = 200,
    parameter int MAX_SCROLL  = 15
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        run,
    input  logic        restart,
    input  logic [9:0]  doodle_y,
    input  logic [3:0]  rd_idx,
    output logic [8:0]  rd_x,
    output logic [8:0]  rd_y,
    output logic [3:0]  doodle_pull,
    output logic        busy,
    output logic        update_done,
    output logic [19:0] score,
    output logic        game_over
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [9:0]  SCREEN_H_V = 10'(SCREEN_H);
    localparam logic [9:0]  SCROLL_V   = 10'(SCROLL_LINE);
    localparam logic [9:0]  MAX_V      = 10'(MAX_SCROLL);
    localparam logic [8:0]  SPAN_V     = 9'(FIELD_W - PLAT_W);
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    logic [1:0]  state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [3:0]  pull_q, pull_d;
    logic [19:0] score_q, score_d;
    logic        go_q, go_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  sync_q, sync_d;
    logic        prev_q, prev_d;

    logic        tick;
    logic [9:0]  scroll_diff;
    logic [3:0]  calc_s;
    logic [20:0] score_sum;
    logic [8:0]  lfsr_l;
    logic [8:0]  spawn_x;
    logic [8:0]  x_arr [NUM_PLAT];
    logic [8:0]  y_arr [NUM_PLAT];

    // frame_clk is foreign to this domain; edge detect after two flops
    always_comb begin
        sync_d = {sync_q[0], frame_clk};
        prev_d = sync_q[1];
        tick   = sync_q[1] & ~prev_q & (state_q == IDLE) & run & ~restart;
    end

    always_comb begin
        lfsr_d = restart ? LFSR_SEED
                         : {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        lfsr_l  = lfsr_q[8:0];
        spawn_x = (lfsr_l >= SPAN_V) ? (lfsr_l - SPAN_V) : lfsr_l;
    end

    always_comb begin
        scroll_diff = SCROLL_V - doodle_y;
        if (go_q || doodle_y >= SCREEN_H_V || doodle_y >= SCROLL_V) begin
            calc_s = 4'd0;
        end else if (scroll_diff > MAX_V) begin
            calc_s = 4'(MAX_SCROLL);
        end else begin
            calc_s = scroll_diff[3:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        pull_d    = pull_q;
        score_d   = score_q;
        go_d      = go_q;
        score_sum = {1'b0, score_q} + 21'(pull_q);
        if (restart) begin
            state_d = IDLE;
            k_d     = 4'd0;
            pull_d  = 4'd0;
            score_d = 20'd0;
            go_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick) state_d = CALC;
                end
                CALC: begin
                    k_d = 4'd0;
                    if (doodle_y >= SCREEN_H_V) begin
                        go_d    = 1'b1;
                        pull_d  = 4'd0;
                        state_d = DONE;
                    end else begin
                        pull_d  = calc_s;
                        state_d = UPDATE;
                    end
                end
                UPDATE: begin
                    k_d = k_q + 4'd1;
                    if (k_q == 4'(NUM_PLAT - 1)) state_d = DONE;
                end
                DONE: begin
                    score_d = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            k_q     <= 4'd0;
            pull_q  <= 4'd0;
            score_q <= 20'd0;
            go_q    <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            sync_q  <= 2'b00;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pull_q  <= pull_d;
            score_q <= score_d;
            go_q    <= go_d;
            lfsr_q  <= lfsr_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAT; gi++) begin : g_slot
            localparam logic [8:0] X_INIT = 9'(16 * gi + 20);
            localparam logic [8:0] Y_INIT = 9'(30 * gi);

            logic [8:0] x_q, x_d;
            logic [8:0] y_q, y_d;
            logic [9:0] t;

            always_comb begin
                x_d = x_q;
                y_d = y_q;
                t   = {1'b0, y_q} + {6'd0, pull_q};
                if (restart) begin
                    x_d = X_INIT;
                    y_d = Y_INIT;
                end else if (state_q == UPDATE && k_q == 4'(gi)) begin
                    // a platform scrolled past the bottom wraps to the top at a fresh X
                    if (t >= SCREEN_H_V) begin
                        y_d = 9'(t - SCREEN_H_V);
                        x_d = spawn_x;
                    end else begin
                        y_d = t[8:0];
                    end
                end
            end

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    x_q <= X_INIT;
                    y_q <= Y_INIT;
                end else begin
                    x_q <= x_d;
                    y_q <= y_d;
                end
            end

            assign x_arr[gi] = x_q;
            assign y_arr[gi] = y_q;
        end
    endgenerate

    assign rd_x        = x_arr[rd_idx];
    assign rd_y        = y_arr[rd_idx];
    assign doodle_pull = pull_q;
    assign busy        = (state_q != IDLE);
    assign update_done = (state_q == DONE);
    assign score       = score_q;
    assign game_over   = go_q;

endmodule

// File: tb/tb_plat_scroll_sched.sv
// Scoreboarded bench for plat_scroll_sched: a frame-level model predicts each
// update; a monitor checks every update_done against the queued expectation.
module tb_plat_scroll_sched;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic        run = 1'b1;
    logic        restart = 1'b0;
    logic [9:0]  doodle_y = 10'd300;
    logic [3:0]  rd_idx = 4'd0;
    logic [8:0]  rd_x, rd_y;
    logic [3:0]  doodle_pull;
    logic        busy, update_done;
    logic [19:0] score;
    logic        game_over;

    plat_scroll_sched dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .run(run),
        .restart(restart), .doodle_y(doodle_y), .rd_idx(rd_idx),
        .rd_x(rd_x), .rd_y(rd_y), .doodle_pull(doodle_pull), .busy(busy),
        .update_done(update_done), .score(score), .game_over(game_over)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        int pull;
        int score;
        int go;
        int blen;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass = 0;

    int   mx[16];
    int   my[16];
    bit   mxk[16];
    int   mscore;
    int   mgo;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mx[i]  = 16 * i + 20;
            my[i]  = 30 * i;
            mxk[i] = 1'b1;
        end
        mscore = 0;
        mgo    = 0;
    endtask

    task automatic check_slots();
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            check($sformatf("slot%0d_y", i), int'(rd_y), my[i]);
            if (mxk[i]) check($sformatf("slot%0d_x", i), int'(rd_x), mx[i]);
            else check($sformatf("slot%0d_x_range", i), int'(rd_x < 9'd280), 1);
        end
    endtask

    // One frame: predict, queue the expectation, then toggle frame_clk.
    task automatic frame(input int dy);
        exp_t e;
        int   s;
        doodle_y = 10'(dy);
        if (run) begin
            if (dy >= 480) begin
                mgo    = 1;
                s      = 0;
                e.blen = 2;
            end else begin
                s = (mgo != 0 || dy >= 200) ? 0 : ((200 - dy > 15) ? 15 : 200 - dy);
                for (int i = 0; i < 16; i++) begin
                    my[i] = my[i] + s;
                    if (my[i] >= 480) begin
                        my[i]  = my[i] - 480;
                        mxk[i] = 1'b0;
                    end
                end
                e.blen = 18;
            end
            mscore  = (mscore + s > 20'hFFFFF) ? 20'hFFFFF : mscore + s;
            e.pull  = s;
            e.score = mscore;
            e.go    = mgo;
            sbq.push_back(e);
        end
        @(negedge Clk) frame_clk = 1'b1;
        repeat (26) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        check("pending_updates", sbq.size(), 0);
        check("game_over", int'(game_over), mgo);
        check_slots();
    endtask

    task automatic restart_idle();
        @(negedge Clk) restart = 1'b1;
        @(negedge Clk) restart = 1'b0;
        model_reset();
    endtask

    // monitor: pops one expectation per update_done
    initial begin
        exp_t e;
        int   bcnt;
        bit   pend;
        bcnt = 0;
        pend = 1'b0;
        e = '{pull: 0, score: 0, go: 0, blen: 0};
        @(posedge Reset_n);
        forever begin
            @(negedge Clk);
            if (busy) bcnt++;
            if (pend) begin
                check("score", int'(score), e.score);
                check("busy_after_done", int'(busy), 0);
                pend = 1'b0;
            end
            if (update_done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_update_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("doodle_pull", int'(doodle_pull), e.pull);
                    check("game_over_at_done", int'(game_over), e.go);
                    check("busy_len", bcnt, e.blen);
                    pend = 1'b1;
                end
                bcnt = 0;
            end else if (!busy) begin
                bcnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int w;
        int ok;
        int r;
        model_reset();

        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        rd_idx = 4'd5;
        #1;
        check("reset_x5", int'(rd_x), 100);
        check("reset_y5", int'(rd_y), 150);
        check("reset_score", int'(score), 0);
        check("reset_game_over", int'(game_over), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pull", int'(doodle_pull), 0);
        check("reset_update_done", int'(update_done), 0);
        check_slots();

        frame(300);
        frame(100);
        frame(190);

        restart_idle();
        for (int f = 0; f < 6; f++) frame(195);

        frame(480);
        frame(100);
        frame(100);
        restart_idle();
        @(negedge Clk);
        check("restart_game_over", int'(game_over), 0);
        check("restart_score", int'(score), 0);
        check_slots();

        // restart in the middle of an s=15 update
        doodle_y = 10'd100;
        @(negedge Clk) frame_clk = 1'b1;
        w = 0;
        while (!busy && w < 10) begin
            @(negedge Clk);
            w++;
        end
        check("abort_busy_seen", int'(busy), 1);
        repeat (7) @(negedge Clk);
        restart = 1'b1;
        @(negedge Clk);
        restart = 1'b0;
        model_reset();
        check("abort_busy_next", int'(busy), 0);
        check("abort_update_done", int'(update_done), 0);
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (30) @(negedge Clk);
        check("abort_score", int'(score), 0);
        check("abort_queue", sbq.size(), 0);
        check_slots();

        // frame edge reaching the tick stage in the same cycle as restart
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        restart = 1'b1;
        @(negedge Clk);
        restart = 1'b0;
        model_reset();
        ok = 1;
        repeat (25) begin
            if (busy) ok = 0;
            @(negedge Clk);
        end
        check("tick_with_restart_dropped", ok, 1);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        check_slots();

        for (int f = 0; f < 30; f++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0 || (mgo != 0 && r < 8)) restart_idle();
            run = (r == 1) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 24) == 0) frame(480 + int'($urandom_range(0, 543)));
            else frame(int'($urandom_range(100, 320)));
        end
        run = 1'b1;

        repeat (5) @(negedge Clk);
        check("final_queue", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
